// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-channel round-robin front end for one external 4-bit ALU
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b0,
  input  logic [3:0] req_b1,
  input  logic [1:0] req_op,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_c,
  output logic       rsp_overflow,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_mod,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_c,
  input  logic       alu_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_ptr;
  logic       r_cur_ch;
  logic       r_cur_op;
  logic [3:0] r_cur_a;
  logic [3:0] r_cur_b;
  logic [3:0] r_res;
  logic       r_zero;
  logic       r_c;
  logic       r_ovf;

  logic       w_any;
  logic       w_gnt;
  logic       w_req_hs;
  logic       w_capture;

  // Priority channel wins a tie; otherwise the lone requester wins.
  always_comb begin
    w_any = |req_valid;
    if (&req_valid) begin
      w_gnt = r_ptr;
    end else begin
      w_gnt = ~req_valid[0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    alu_a       = 4'h0;
    alu_b       = 4'h0;
    alu_mod     = 3'b111;
    w_req_hs    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready[w_gnt] = 1'b1;
          w_req_hs         = 1'b1;
          w_state_nxt      = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a       = r_cur_a;
        alu_b       = r_cur_b;
        alu_mod     = {2'b00, r_cur_op};
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_cur_ch] = 1'b1;
        if (rsp_ready[r_cur_ch]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'(RR_INIT);
      r_cur_ch <= 1'b0;
      r_cur_op <= 1'b0;
      r_cur_a  <= 4'h0;
      r_cur_b  <= 4'h0;
      r_res    <= 4'h0;
      r_zero   <= 1'b0;
      r_c      <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_ptr    <= ~w_gnt;
        r_cur_ch <= w_gnt;
        r_cur_op <= req_op[w_gnt];
        r_cur_a  <= w_gnt ? req_a1 : req_a0;
        r_cur_b  <= w_gnt ? req_b1 : req_b0;
      end
      if (w_capture) begin
        r_res  <= alu_result;
        r_zero <= alu_zero;
        r_c    <= alu_c;
        r_ovf  <= alu_overflow;
      end
    end
  end

  assign rsp_result   = r_res;
  assign rsp_zero     = r_zero;
  assign rsp_c        = r_c;
  assign rsp_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed-vector bench for alu_arbiter with a behavioural ALU
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req_a0 = 4'h0;
  logic [3:0] req_a1 = 4'h0;
  logic [3:0] req_b0 = 4'h0;
  logic [3:0] req_b1 = 4'h0;
  logic [1:0] req_op = 2'b00;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_c;
  logic       rsp_overflow;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_mod;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_c;
  logic       alu_overflow;

  logic [3:0] r_corrupt = 4'h0;
  logic [4:0] w_sum;
  logic       mon_en = 1'b0;
  int         n_chk  = 0;
  int         n_pass = 0;

  alu_arbiter #(.RR_INIT(0)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (req_a0),
    .req_a1       (req_a1),
    .req_b0       (req_b0),
    .req_b1       (req_b1),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_c        (rsp_c),
    .rsp_overflow (rsp_overflow),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_mod      (alu_mod),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_c        (alu_c),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  // External ALU; r_corrupt lets the bench wiggle alu_result while it must be ignored.
  always_comb begin
    w_sum        = 5'd0;
    alu_result   = r_corrupt;
    alu_zero     = 1'b0;
    alu_c        = 1'b0;
    alu_overflow = 1'b0;
    if (alu_mod == 3'b000 || alu_mod == 3'b001) begin
      if (alu_mod == 3'b000) begin
        w_sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[3] == alu_b[3]) && (w_sum[3] != alu_a[3]);
      end else begin
        w_sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_overflow = (alu_a[3] != alu_b[3]) && (w_sum[3] != alu_a[3]);
      end
      alu_result = w_sum[3:0] ^ r_corrupt;
      alu_c      = w_sum[4];
      alu_zero   = (w_sum[3:0] == 4'h0);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      #2 chk("ready_never_both", {7'd0, &req_ready}, 8'd0);
    end
  end

  task automatic do_op(input logic ch, input logic [3:0] a, input logic [3:0] b,
                       input logic op, input logic [3:0] er, input logic ez,
                       input logic ec, input logic ev);
    logic [1:0] m;
    m = ch ? 2'b10 : 2'b01;
    @(negedge clk);
    if (ch) begin req_a1 = a; req_b1 = b; end
    else    begin req_a0 = a; req_b0 = b; end
    req_op[ch] = op;
    req_valid  = m;
    rsp_ready  = 2'b00;
    #1;
    chk("op_req_ready", {6'd0, req_ready}, {6'd0, m});
    chk("op_idle_mod", {5'd0, alu_mod}, 8'd7);
    @(negedge clk);
    req_valid = 2'b00;
    req_a0 = 4'hC; req_b0 = 4'h5; req_a1 = 4'h3; req_b1 = 4'hA; req_op = ~req_op;
    #1;
    chk("op_exec_mod", {5'd0, alu_mod}, {6'd0, 1'b0, op});
    chk("op_exec_a", {4'd0, alu_a}, {4'd0, a});
    chk("op_exec_b", {4'd0, alu_b}, {4'd0, b});
    chk("op_exec_rspv", {6'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("op_rsp_valid", {6'd0, rsp_valid}, {6'd0, m});
    chk("op_rsp_result", {4'd0, rsp_result}, {4'd0, er});
    chk("op_rsp_zero", {7'd0, rsp_zero}, {7'd0, ez});
    chk("op_rsp_c", {7'd0, rsp_c}, {7'd0, ec});
    chk("op_rsp_ovf", {7'd0, rsp_overflow}, {7'd0, ev});
    chk("op_rsp_ready0", {6'd0, req_ready}, 8'd0);
    chk("op_rsp_mod", {5'd0, alu_mod}, 8'd7);
    rsp_ready = m;
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    chk("op_back_idle", {6'd0, rsp_valid}, 8'd0);
    chk("op_back_mod", {5'd0, alu_mod}, 8'd7);
  endtask

  logic [1:0] t_ready [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
  logic [1:0] t_rspv  [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
  logic [2:0] t_mod   [7] = '{3'd7, 3'd0, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7};
  logic [3:0] t_a     [7] = '{4'd0, 4'd3, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0};
  logic [3:0] t_b     [7] = '{4'd0, 4'd4, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0};
  logic [3:0] t_res   [7] = '{4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd8, 4'd0};
  logic       t_ovf   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {6'd0, req_ready}, 8'd0);
    chk("rst_rsp_valid", {6'd0, rsp_valid}, 8'd0);
    chk("rst_rsp_result", {4'd0, rsp_result}, 8'd0);
    chk("rst_flags", {5'd0, rsp_zero, rsp_c, rsp_overflow}, 8'd0);
    chk("rst_alu_mod", {5'd0, alu_mod}, 8'd7);
    chk("rst_alu_ab", {alu_a, alu_b}, 8'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1 chk("idle_req_ready", {6'd0, req_ready}, 8'd0);

    do_op(1'b0, 4'd7, 4'd9, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    do_op(1'b1, 4'd8, 4'd1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
    do_op(1'b1, 4'd5, 4'd5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);

    // Alternation: both channels always valid, responses always accepted.
    @(negedge clk);
    req_a0 = 4'd3; req_b0 = 4'd4; req_a1 = 4'd4; req_b1 = 4'd4; req_op = 2'b00;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("alt_ready", {6'd0, req_ready}, {6'd0, t_ready[i]});
      chk("alt_rspv", {6'd0, rsp_valid}, {6'd0, t_rspv[i]});
      chk("alt_mod", {5'd0, alu_mod}, {5'd0, t_mod[i]});
      chk("alt_ab", {alu_a, alu_b}, {t_a[i], t_b[i]});
      if (t_rspv[i] != 2'b00) begin
        chk("alt_result", {4'd0, rsp_result}, {4'd0, t_res[i]});
        chk("alt_flags", {5'd0, rsp_zero, rsp_c, rsp_overflow}, {7'd0, t_ovf[i]});
      end
      @(negedge clk);
    end

    // Third grant (ch0, 3+4) is now in EXEC; stall its response.
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_a0    = 4'(i);
      req_b0    = 4'(15 - i);
      r_corrupt = 4'(i + 1);
      req_valid = 2'b11;
      rsp_ready = 2'b10;
      #1;
      chk("hold_rspv", {6'd0, rsp_valid}, 8'd1);
      chk("hold_result", {4'd0, rsp_result}, 8'd7);
      chk("hold_flags", {5'd0, rsp_zero, rsp_c, rsp_overflow}, 8'd0);
      chk("hold_req_ready", {6'd0, req_ready}, 8'd0);
      chk("hold_mod", {5'd0, alu_mod}, 8'd7);
      @(negedge clk);
    end
    r_corrupt = 4'h0;
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    #1 chk("hold_last_rspv", {6'd0, rsp_valid}, 8'd1);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk("hold_released", {6'd0, rsp_valid}, 8'd0);

    // Reset during EXEC; pointer is 1 beforehand, so 01 after reset proves it reloaded.
    @(negedge clk);
    req_a0 = 4'd2; req_b0 = 4'd3; req_op = 2'b00; req_valid = 2'b01;
    #1 chk("rx_req_ready", {6'd0, req_ready}, 8'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("rx_in_exec", {5'd0, alu_mod}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("rx_mod", {5'd0, alu_mod}, 8'd7);
    chk("rx_ab", {alu_a, alu_b}, 8'd0);
    chk("rx_rspv", {6'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rx_no_stale0", {6'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    #1 chk("rx_no_stale1", {6'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("rx_ptr_init", {6'd0, req_ready}, 8'd1);
    req_valid = 2'b00;

    // Reset during RESP.
    @(negedge clk);
    req_a0 = 4'd1; req_b0 = 4'd1; req_op = 2'b00; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rr_in_resp", {6'd0, rsp_valid}, 8'd1);
    chk("rr_result", {4'd0, rsp_result}, 8'd2);
    rst_n = 1'b0;
    #1;
    chk("rr_rspv", {6'd0, rsp_valid}, 8'd0);
    chk("rr_result_clr", {4'd0, rsp_result}, 8'd0);
    chk("rr_flags_clr", {5'd0, rsp_zero, rsp_c, rsp_overflow}, 8'd0);
    chk("rr_mod", {5'd0, alu_mod}, 8'd7);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rr_no_stale0", {6'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    #1 chk("rr_no_stale1", {6'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("rr_ptr_init", {6'd0, req_ready}, 8'd1);
    req_valid = 2'b00;

    @(negedge clk);
    mon_en = 1'b0;
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
